// File: rtl/fdivu4_seq.sv
// fdivu4_seq: 4-bit unsigned restoring divider, one quotient bit per clock.
// Internal FSM (IDLE/CALC/FIN) is followed by one output register stage, so
// BUSY/DONE/Q/R/DZ trail the state by one cycle and never see inputs
// combinationally. W holds the dividend and collects quotient bits from the
// right; P is the partial remainder.
module fdivu4_seq (
  input  logic CK,
  input  logic CD,
  input  logic START,
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic R0,
  output logic R1,
  output logic R2,
  output logic R3,
  output logic BUSY,
  output logic DONE,
  output logic DZ
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  state_t      state, state_n;
  logic [3:0]  n, d;
  logic [3:0]  w, v, p;
  logic [1:0]  cnt;
  logic        dzf;
  logic [4:0]  t;
  logic        accept;
  logic        busy_d, done_d;
  logic [3:0]  q, r;
  logic        busy, done, dz;

  assign n = {N3, N2, N1, N0};
  assign d = {D3, D2, D1, D0};

  // A request is taken whenever the block is not iterating
  assign accept = START && (state != CALC);

  // Trial subtraction at 5 bits; t[4] is the borrow
  assign t = {p, w[3]} - {1'b0, v};

  // State register
  always_ff @(posedge CK or posedge CD) begin
    if (CD) state <= IDLE;
    else    state <= state_n;
  end

  // Next-state decision
  always_comb begin
    state_n = state;
    case (state)
      IDLE, FIN: begin
        if (START) state_n = (d != 4'd0) ? CALC : FIN;
        else       state_n = IDLE;
      end
      CALC:    state_n = (cnt == 2'd0) ? FIN : CALC;
      default: state_n = IDLE;
    endcase
  end

  // Output decode from state, registered below
  always_comb begin
    busy_d = (state == CALC);
    done_d = (state == FIN);
  end

  // Working registers: load on accept, shift/subtract while in CALC
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      w   <= 4'd0;
      v   <= 4'd0;
      p   <= 4'd0;
      cnt <= 2'd0;
      dzf <= 1'b0;
    end else if (accept) begin
      v <= d;
      if (d != 4'd0) begin
        w   <= n;
        p   <= 4'd0;
        cnt <= 2'd3;
        dzf <= 1'b0;
      end else begin
        // Divide by zero: result is staged directly, no iterations
        w   <= 4'hf;
        p   <= n;
        cnt <= 2'd0;
        dzf <= 1'b1;
      end
    end else if (state == CALC) begin
      w   <= {w[2:0], ~t[4]};
      p   <= t[4] ? {p[2:0], w[3]} : t[3:0];
      cnt <= (cnt != 2'd0) ? cnt - 2'd1 : 2'd0;
    end
  end

  // Output stage: result registers move only when FIN is presented
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      busy <= 1'b0;
      done <= 1'b0;
      dz   <= 1'b0;
      q    <= 4'd0;
      r    <= 4'd0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (done_d) begin
        q  <= w;
        r  <= p;
        dz <= dzf;
      end
    end
  end

  assign {Q3, Q2, Q1, Q0} = q;
  assign {R3, R2, R1, R0} = r;
  assign BUSY = busy;
  assign DONE = done;
  assign DZ   = dz;

endmodule

// File: tb/tb_fdivu4_seq.sv
// Bench for fdivu4_seq: a cycle-level model (request acceptance, result due
// times, N/D arithmetic) is compared every cycle; directed cases add literal
// expectations for latency and values.
module tb_fdivu4_seq;

  logic CK = 1'b0;
  logic CD = 1'b1;
  logic START = 1'b0;
  logic [3:0] nv = 4'd0;
  logic [3:0] dv = 4'd0;
  logic Q0, Q1, Q2, Q3, R0, R1, R2, R3, BUSY, DONE, DZ;
  logic [3:0] q, r;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;

  assign q = {Q3, Q2, Q1, Q0};
  assign r = {R3, R2, R1, R0};

  fdivu4_seq dut (
    .CK(CK), .CD(CD), .START(START),
    .N0(nv[0]), .N1(nv[1]), .N2(nv[2]), .N3(nv[3]),
    .D0(dv[0]), .D1(dv[1]), .D2(dv[2]), .D3(dv[3]),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .BUSY(BUSY), .DONE(DONE), .DZ(DZ)
  );

  always #5 CK = ~CK;

  // Model state: expected outputs after the most recent edge
  int ecnt = 0, free_e = 0, due = 0, busy_lo = 1, busy_hi = 0;
  logic pend = 1'b0;
  logic [3:0] pq = 4'd0, pr = 4'd0;
  logic pdz = 1'b0;
  logic e_busy = 1'b0, e_done = 1'b0, e_dz = 1'b0;
  logic [3:0] e_q = 4'd0, e_r = 4'd0;

  initial forever begin
    @(posedge CK or posedge CD);
    if (CD) begin
      ecnt = 0; free_e = 0; pend = 1'b0; busy_lo = 1; busy_hi = 0;
      e_busy = 1'b0; e_done = 1'b0; e_dz = 1'b0; e_q = 4'd0; e_r = 4'd0;
    end else begin
      ecnt++;
      e_done = 1'b0;
      if (pend && due == ecnt) begin
        e_done = 1'b1; e_q = pq; e_r = pr; e_dz = pdz; pend = 1'b0;
      end
      e_busy = (ecnt >= busy_lo) && (ecnt <= busy_hi);
      if (START && ecnt >= free_e) begin
        if (dv == 4'd0) begin
          pq = 4'hf; pr = nv; pdz = 1'b1; due = ecnt + 1; free_e = ecnt + 1;
        end else begin
          pq = nv / dv; pr = nv % dv; pdz = 1'b0;
          due = ecnt + 5; free_e = ecnt + 5;
          busy_lo = ecnt + 1; busy_hi = ecnt + 4;
        end
        pend = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge CK);
    if (!CD) begin
      checks++;
      if ({BUSY, DONE, DZ, q, r} !== {e_busy, e_done, e_dz, e_q, e_r}) begin
        errors++;
        $display("FAIL cycle t=%0t busy/done/dz/q/r got %b/%b/%b/%0d/%0d need %b/%b/%b/%0d/%0d",
                 $time, BUSY, DONE, DZ, q, r, e_busy, e_done, e_dz, e_q, e_r);
      end
    end
  end

  initial forever begin
    @(negedge CK);
    if (DONE === 1'b1) ndone++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end by time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic ok, input int got, input int need);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %0d need %0d", nm, got, need);
    end
  endtask

  // Wait for DONE; expect it on negedge number exp_cyc from now
  task automatic wait_done(input int exp_cyc, input logic [3:0] eq, input logic [3:0] er,
                           input logic edz, input logic chk_end, input string nm);
    int cyc;
    cyc = 0;
    do begin
      @(negedge CK);
      cyc++;
    end while (DONE !== 1'b1 && cyc < 20);
    chk({nm, " latency"}, DONE === 1'b1 && cyc == exp_cyc, cyc, exp_cyc);
    chk({nm, " q"}, q === eq, q, eq);
    chk({nm, " r"}, r === er, r, er);
    chk({nm, " dz"}, DZ === edz, DZ, edz);
    if (chk_end) begin
      @(negedge CK);
      chk({nm, " done pulse end"}, DONE === 1'b0, DONE, 0);
    end
  endtask

  task automatic run(input logic [3:0] n, input logic [3:0] d, input logic [3:0] eq,
                     input logic [3:0] er, input logic edz, input string nm);
    @(posedge CK); #2;
    nv = n; dv = d; START = 1'b1;
    @(posedge CK); #2;
    START = 1'b0; nv = 4'($urandom); dv = 4'($urandom);
    wait_done((d == 4'd0) ? 2 : 6, eq, er, edz, 1'b1, nm);
  endtask

  initial begin
    #1;
    chk("reset outputs", {BUSY, DONE, DZ, q, r} === 11'd0, {BUSY, DONE, DZ, q, r}, 0);
    #20 CD = 1'b0;

    run(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, "13/3");
    run(4'd5,  4'd7, 4'd0,  4'd5, 1'b0, "5/7");
    run(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, "15/1");
    run(4'd9,  4'd0, 4'd15, 4'd9, 1'b1, "9/0");
    run(4'd8,  4'd2, 4'd4,  4'd0, 1'b0, "8/2");

    // START during CALC is ignored
    @(posedge CK); #2;
    nv = 4'd13; dv = 4'd3; START = 1'b1;
    @(posedge CK); #2;
    START = 1'b0;
    @(posedge CK); #2;
    START = 1'b1; nv = 4'd1; dv = 4'd1;
    @(posedge CK); #2;
    START = 1'b0;
    wait_done(4, 4'd4, 4'd1, 1'b0, 1'b1, "ignored start");

    // Back-to-back: START present on the DONE edge
    @(posedge CK); #2;
    nv = 4'd5; dv = 4'd7; START = 1'b1;
    @(posedge CK); #2;
    START = 1'b0;
    repeat (4) @(posedge CK);
    #2;
    nv = 4'd14; dv = 4'd4; START = 1'b1;
    @(posedge CK); #2;
    START = 1'b0;
    wait_done(1, 4'd0, 4'd5, 1'b0, 1'b0, "b2b first");
    wait_done(5, 4'd3, 4'd2, 1'b0, 1'b1, "b2b second");

    // Asynchronous reset mid-CALC
    @(posedge CK); #2;
    nv = 4'd13; dv = 4'd3; START = 1'b1;
    @(posedge CK); #2;
    START = 1'b0;
    @(posedge CK); #3;
    CD = 1'b1;
    #1;
    chk("async reset outputs", {BUSY, DONE, DZ, q, r} === 11'd0, {BUSY, DONE, DZ, q, r}, 0);
    #2 CD = 1'b0;
    ndone = 0;
    repeat (8) @(negedge CK);
    chk("no done after abort", ndone == 0, ndone, 0);
    run(4'd8, 4'd2, 4'd4, 4'd0, 1'b0, "after abort");

    // Exhaustive back-to-back sweep
    @(posedge CK); #2;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        nv = 4'(i); dv = 4'(j); START = 1'b1;
        repeat ((j == 0) ? 1 : 5) @(posedge CK);
        #2;
      end
    end
    START = 1'b0;
    repeat (8) @(negedge CK);
    chk("exhaustive done count", ndone == 256, ndone, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
